// File: rtl/ex_mem_skid_buffer.sv
// ex_mem_skid_buffer
//   Registered EX->MEM pipeline boundary built as a two-entry skid buffer.
//   The main register drives the MEM-side outputs. The skid register catches
//   the one entry that EX may still push in the cycle after MEM stalls.
//   ready_o comes straight from a flop, so there is no combinational path
//   from ready_i back to ready_o.
//   An ALU overflow on an accepted entry is counted in a saturating counter.
//   With TRAP_ON_OVERFLOW = 1 the entry becomes a precise exception, and
//   intake stops until a flush.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   flush_i                 drop all buffered entries and clear the halt
//   valid_i / ready_o       EX-side handshake (ready_o is registered)
//   alu_result_i, zero_i, overflow_i, store_data_i, pc_i, rd_addr_i,
//   reg_write_i, mem_read_i, mem_write_i   EX payload
//   valid_o / ready_i       MEM-side handshake
//   alu_result_o, zero_o, store_data_o, pc_o, rd_addr_o, reg_write_o,
//   mem_read_o, mem_write_o, exc_o          registered MEM payload
//   halted_o                intake blocked after an overflow exception
//   ovf_count_o             saturating count of accepted overflow entries
module ex_mem_skid_buffer #(
  parameter int XLEN             = 32,
  parameter bit TRAP_ON_OVERFLOW = 1'b0,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [XLEN-1:0]      alu_result_i,
  input  logic                 zero_i,
  input  logic                 overflow_i,
  input  logic [XLEN-1:0]      store_data_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic [4:0]           rd_addr_i,
  input  logic                 reg_write_i,
  input  logic                 mem_read_i,
  input  logic                 mem_write_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [XLEN-1:0]      alu_result_o,
  output logic [XLEN-1:0]      store_data_o,
  output logic [XLEN-1:0]      pc_o,
  output logic                 zero_o,
  output logic [4:0]           rd_addr_o,
  output logic                 reg_write_o,
  output logic                 mem_read_o,
  output logic                 mem_write_o,
  output logic                 exc_o,
  output logic                 halted_o,
  output logic [CNT_WIDTH-1:0] ovf_count_o
);

  // Entry layout from MSB to LSB:
  //   alu_result | store_data | pc | rd_addr | zero | reg_write | mem_read |
  //   mem_write | exc
  localparam int PW = 3*XLEN + 5 + 5;

  // Buffer occupancy. The halt condition is kept in its own flop so the
  // entries already buffered can drain normally while intake is blocked.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t                 state_reg, state_next;
  logic [PW-1:0]        main_reg, main_next;
  logic [PW-1:0]        skid_reg, skid_next;
  logic                 halted_reg, halted_next;
  logic                 ready_reg, ready_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;

  logic          main_valid;
  logic          accept;
  logic          drain;
  logic          trap_in;
  logic [PW-1:0] entry_in;

  assign main_valid = (state_reg != EMPTY);
  // A flushed input is neither stored nor counted.
  assign accept     = valid_i && ready_reg && !flush_i;
  assign drain      = main_valid && ready_i;
  assign trap_in    = TRAP_ON_OVERFLOW && overflow_i;

  // A trapping entry must not have side effects in later stages, so its
  // write and memory controls are cleared.
  assign entry_in = {alu_result_i, store_data_i, pc_i, rd_addr_i, zero_i,
                     reg_write_i && !trap_in, mem_read_i && !trap_in,
                     mem_write_i && !trap_in, trap_in};

  always_comb begin
    state_next  = state_reg;
    main_next   = main_reg;
    skid_next   = skid_reg;
    halted_next = halted_reg;
    cnt_next    = cnt_reg;

    case (state_reg)
      EMPTY: begin
        if (accept) begin
          main_next  = entry_in;
          state_next = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          main_next = entry_in;
        end else if (accept) begin
          skid_next  = entry_in;
          state_next = FULL;
        end else if (drain) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        // ready_o is low in FULL, so no accept can arrive here.
        if (drain) begin
          main_next  = skid_reg;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase

    if (accept && trap_in) begin
      halted_next = 1'b1;
    end

    if (accept && overflow_i && (cnt_reg != {CNT_WIDTH{1'b1}})) begin
      cnt_next = cnt_reg + 1'b1;
    end

    if (flush_i) begin
      state_next  = EMPTY;
      halted_next = 1'b0;
    end

    // Registered ready: it reflects the occupancy and halt state that will
    // hold after this edge.
    ready_next = (state_next != FULL) && !halted_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= EMPTY;
      main_reg   <= '0;
      skid_reg   <= '0;
      halted_reg <= 1'b0;
      ready_reg  <= 1'b1;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      main_reg   <= main_next;
      skid_reg   <= skid_next;
      halted_reg <= halted_next;
      ready_reg  <= ready_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign ready_o     = ready_reg;
  assign valid_o     = main_valid;
  assign halted_o    = halted_reg;
  assign ovf_count_o = cnt_reg;

  assign {alu_result_o, store_data_o, pc_o, rd_addr_o, zero_o,
          reg_write_o, mem_read_o, mem_write_o, exc_o} = main_reg;

endmodule

// File: tb/tb_ex_mem_skid_buffer.sv
// Directed bench for ex_mem_skid_buffer. Three instances share one set of
// inputs:
//   dut_a  TRAP_ON_OVERFLOW = 0, CNT_WIDTH = 16
//   dut_b  TRAP_ON_OVERFLOW = 1, CNT_WIDTH = 16
//   dut_c  TRAP_ON_OVERFLOW = 0, CNT_WIDTH = 2
module tb_ex_mem_skid_buffer;

  logic clk = 1'b0;
  logic rst, flush, valid_i, ready_i, zero_i, overflow_i;
  logic reg_write_i, mem_read_i, mem_write_i;
  logic [31:0] alu_i, store_i, pc_i;
  logic [4:0]  rd_i;

  // Outputs of dut_a
  logic a_ready, a_valid, a_zero, a_rw, a_mr, a_mw, a_exc, a_halted;
  logic [31:0] a_alu, a_store, a_pc;
  logic [4:0]  a_rd;
  logic [15:0] a_cnt;
  // Outputs of dut_b
  logic b_ready, b_valid, b_zero, b_rw, b_mr, b_mw, b_exc, b_halted;
  logic [31:0] b_alu, b_store, b_pc;
  logic [4:0]  b_rd;
  logic [15:0] b_cnt;
  // Outputs of dut_c
  logic c_ready, c_valid, c_zero, c_rw, c_mr, c_mw, c_exc, c_halted;
  logic [31:0] c_alu, c_store, c_pc;
  logic [4:0]  c_rd;
  logic [1:0]  c_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_skid_buffer #(.XLEN(32), .TRAP_ON_OVERFLOW(1'b0), .CNT_WIDTH(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_i), .ready_o(a_ready),
    .alu_result_i(alu_i), .zero_i(zero_i), .overflow_i(overflow_i),
    .store_data_i(store_i), .pc_i(pc_i), .rd_addr_i(rd_i),
    .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .valid_o(a_valid), .ready_i(ready_i), .alu_result_o(a_alu), .store_data_o(a_store),
    .pc_o(a_pc), .zero_o(a_zero), .rd_addr_o(a_rd), .reg_write_o(a_rw),
    .mem_read_o(a_mr), .mem_write_o(a_mw), .exc_o(a_exc), .halted_o(a_halted),
    .ovf_count_o(a_cnt));

  ex_mem_skid_buffer #(.XLEN(32), .TRAP_ON_OVERFLOW(1'b1), .CNT_WIDTH(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_i), .ready_o(b_ready),
    .alu_result_i(alu_i), .zero_i(zero_i), .overflow_i(overflow_i),
    .store_data_i(store_i), .pc_i(pc_i), .rd_addr_i(rd_i),
    .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .valid_o(b_valid), .ready_i(ready_i), .alu_result_o(b_alu), .store_data_o(b_store),
    .pc_o(b_pc), .zero_o(b_zero), .rd_addr_o(b_rd), .reg_write_o(b_rw),
    .mem_read_o(b_mr), .mem_write_o(b_mw), .exc_o(b_exc), .halted_o(b_halted),
    .ovf_count_o(b_cnt));

  ex_mem_skid_buffer #(.XLEN(32), .TRAP_ON_OVERFLOW(1'b0), .CNT_WIDTH(2)) dut_c (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_i), .ready_o(c_ready),
    .alu_result_i(alu_i), .zero_i(zero_i), .overflow_i(overflow_i),
    .store_data_i(store_i), .pc_i(pc_i), .rd_addr_i(rd_i),
    .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .valid_o(c_valid), .ready_i(ready_i), .alu_result_o(c_alu), .store_data_o(c_store),
    .pc_o(c_pc), .zero_o(c_zero), .rd_addr_o(c_rd), .reg_write_o(c_rw),
    .mem_read_o(c_mr), .mem_write_o(c_mw), .exc_o(c_exc), .halted_o(c_halted),
    .ovf_count_o(c_cnt));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; valid_i = 0; zero_i = 0; overflow_i = 0;
    reg_write_i = 0; mem_read_i = 0; mem_write_i = 0;
    alu_i = '0; store_i = '0; pc_i = '0; rd_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  initial begin
    rst = 0; ready_i = 0;
    idle_inputs();
    #2;

    // ---------------- Reset state ----------------
    do_reset();
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_ready", 32'(a_ready), 32'd1);
    check("rst_cnt",   32'(a_cnt),   32'd0);
    check("rst_halt_b", 32'(b_halted), 32'd0);

    // ---------------- Streaming 1..8 with ready_i = 1 ----------------
    ready_i = 1;
    for (int k = 1; k <= 8; k++) begin
      valid_i = 1; alu_i = 32'(k); store_i = 32'(k * 3);
      pc_i = 32'h1000 + 32'(k * 4); rd_i = 5'(k); reg_write_i = 1;
      step();
      $display("stream k=%0d valid=%0d alu=%0h pc=%0h ready=%0d", k, a_valid, a_alu, a_pc, a_ready);
      check("stream_valid", 32'(a_valid), 32'd1);
      check("stream_alu",   a_alu, 32'(k));
      check("stream_store", a_store, 32'(k * 3));
      check("stream_pc",    a_pc, 32'h1000 + 32'(k * 4));
      check("stream_rd",    32'(a_rd), 32'(k));
      check("stream_ready", 32'(a_ready), 32'd1);
    end
    idle_inputs();
    step();
    check("stream_drained", 32'(a_valid), 32'd0);

    // ---------------- Backpressure ----------------
    do_reset();
    ready_i = 0;
    valid_i = 1; alu_i = 32'h10;
    step();
    $display("bp push A valid=%0d alu=%0h ready=%0d", a_valid, a_alu, a_ready);
    check("bp_a_valid", 32'(a_valid), 32'd1);
    check("bp_a_alu",   a_alu, 32'h10);
    check("bp_a_ready", 32'(a_ready), 32'd1);
    alu_i = 32'h20;
    step();
    $display("bp push B valid=%0d alu=%0h ready=%0d", a_valid, a_alu, a_ready);
    check("bp_b_ready", 32'(a_ready), 32'd0);
    check("bp_b_hold",  a_alu, 32'h10);
    valid_i = 0; alu_i = 32'h99;
    step();
    check("bp_stall_hold",  a_alu, 32'h10);
    check("bp_stall_ready", 32'(a_ready), 32'd0);
    ready_i = 1;
    step();
    $display("bp drain1 valid=%0d alu=%0h ready=%0d", a_valid, a_alu, a_ready);
    check("bp_drain1_valid", 32'(a_valid), 32'd1);
    check("bp_drain1_alu",   a_alu, 32'h20);
    check("bp_drain1_ready", 32'(a_ready), 32'd1);
    step();
    check("bp_drain2_valid", 32'(a_valid), 32'd0);
    check("bp_drain2_ready", 32'(a_ready), 32'd1);

    // ---------------- Trap on overflow (dut_b) ----------------
    do_reset();
    ready_i = 1;
    valid_i = 1; alu_i = 32'h7FFF_FFFF; overflow_i = 1; reg_write_i = 1;
    step();
    $display("trap push exc=%0d rw=%0d halted=%0d ready=%0d cnt=%0d", b_exc, b_rw, b_halted, b_ready, b_cnt);
    check("trap_valid",  32'(b_valid), 32'd1);
    check("trap_alu",    b_alu, 32'h7FFF_FFFF);
    check("trap_exc",    32'(b_exc), 32'd1);
    check("trap_rw",     32'(b_rw), 32'd0);
    check("trap_halted", 32'(b_halted), 32'd1);
    check("trap_ready",  32'(b_ready), 32'd0);
    check("trap_cnt",    32'(b_cnt), 32'd1);
    check("notrap_exc",  32'(a_exc), 32'd0);
    check("notrap_rw",   32'(a_rw), 32'd1);
    check("notrap_halt", 32'(a_halted), 32'd0);
    check("notrap_cnt",  32'(a_cnt), 32'd1);
    // Offered while halted: must be refused; the trap entry still drains.
    overflow_i = 0; reg_write_i = 0; alu_i = 32'h55;
    step();
    check("halt_drained", 32'(b_valid), 32'd0);
    check("halt_ready",   32'(b_ready), 32'd0);
    check("halt_still",   32'(b_halted), 32'd1);
    valid_i = 0; flush = 1;
    step();
    flush = 0;
    $display("trap flush halted=%0d ready=%0d cnt=%0d", b_halted, b_ready, b_cnt);
    check("flush_ready_b",  32'(b_ready), 32'd1);
    check("flush_halted_b", 32'(b_halted), 32'd0);
    check("flush_cnt_b",    32'(b_cnt), 32'd1);

    // ---------------- Flush while FULL with a simultaneous input ----------------
    do_reset();
    ready_i = 0;
    valid_i = 1; alu_i = 32'hA1;
    step();
    alu_i = 32'hA2;
    step();
    check("ff_full_ready", 32'(a_ready), 32'd0);
    flush = 1; alu_i = 32'hA3; overflow_i = 1;
    step();
    idle_inputs();
    $display("flush full valid=%0d ready=%0d cnt=%0d", a_valid, a_ready, a_cnt);
    check("ff_valid", 32'(a_valid), 32'd0);
    check("ff_ready", 32'(a_ready), 32'd1);
    check("ff_cnt",   32'(a_cnt), 32'd0);
    ready_i = 1;
    step();
    check("ff_nolater1", 32'(a_valid), 32'd0);
    step();
    check("ff_nolater2", 32'(a_valid), 32'd0);
    // Flush in ONE while ready_o = 1 and an overflow input is offered.
    valid_i = 1; alu_i = 32'hB1;
    step();
    check("f1_valid", 32'(a_valid), 32'd1);
    flush = 1; alu_i = 32'hB2; overflow_i = 1;
    step();
    idle_inputs();
    check("f1_flushed", 32'(a_valid), 32'd0);
    check("f1_cnt",     32'(a_cnt), 32'd0);
    step();
    check("f1_nolater", 32'(a_valid), 32'd0);

    // ---------------- Counter saturation (dut_c, CNT_WIDTH = 2) ----------------
    do_reset();
    ready_i = 1;
    valid_i = 1; overflow_i = 1;
    for (int k = 1; k <= 5; k++) begin
      alu_i = 32'(k);
      step();
      $display("sat k=%0d cnt=%0d", k, c_cnt);
      check("sat_cnt", 32'(c_cnt), (k < 3) ? 32'(k) : 32'd3);
    end
    idle_inputs();
    check("sat_a_cnt", 32'(a_cnt), 32'd5);

    // ---------------- Reset while FULL ----------------
    do_reset();
    ready_i = 0;
    valid_i = 1; alu_i = 32'hC1; store_i = 32'hDEAD; pc_i = 32'h400; rd_i = 5'd7;
    reg_write_i = 1; overflow_i = 1;
    step();
    alu_i = 32'hC2;
    step();
    check("rf_full_ready", 32'(a_ready), 32'd0);
    check("rf_full_cnt",   32'(a_cnt), 32'd2);
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
    $display("reset full valid=%0d ready=%0d alu=%0h cnt=%0d", a_valid, a_ready, a_alu, a_cnt);
    check("rf_valid", 32'(a_valid), 32'd0);
    check("rf_ready", 32'(a_ready), 32'd1);
    check("rf_alu",   a_alu, 32'd0);
    check("rf_store", a_store, 32'd0);
    check("rf_pc",    a_pc, 32'd0);
    check("rf_rd",    32'(a_rd), 32'd0);
    check("rf_rw",    32'(a_rw), 32'd0);
    check("rf_cnt",   32'(a_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
